garnet_shell: RTL and testbench

- Reduced Garnet top-level shell. Exposes the same external interfaces: processor packet port, AXI4-lite control slave, JTAG, matrix-unit input and interrupt.
- Processor packets read and write a 64-bit global-buffer memory model.
- AXI4-lite accesses a small control/status register file. The register file runs a cycle-counted "kernel" and raises an interrupt.
- The matrix-unit port is reduced to a lane-sum capture.

---
 rtl/garnet_shell.sv | 255 +++++++++++++++++++++++++
 tb/tb_garnet_shell.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/garnet_shell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : garnet_shell                                                    |
// | Purpose  : Reduced Garnet top: global-buffer memory, AXI4-lite CSRs,       |
// |            run engine, matrix-unit lane-sum capture and gated run clock.   |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module garnet_shell #(
    parameter int AXI_ADDR_WIDTH  = 13,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int PROC_ADDR_WIDTH = 19,
    parameter int PROC_DATA_WIDTH = 64,
    parameter int GLB_WORDS       = 1024
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    output logic                         interrupt,
    output logic                         cgra_running_clk_out,
    input  logic                         proc_packet_wr_en,
    input  logic [PROC_DATA_WIDTH/8-1:0] proc_packet_wr_strb,
    input  logic [PROC_ADDR_WIDTH-1:0]   proc_packet_wr_addr,
    input  logic [PROC_DATA_WIDTH-1:0]   proc_packet_wr_data,
    input  logic                         proc_packet_rd_en,
    input  logic [PROC_ADDR_WIDTH-1:0]   proc_packet_rd_addr,
    output logic [PROC_DATA_WIDTH-1:0]   proc_packet_rd_data,
    output logic                         proc_packet_rd_data_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]    axi4_slave_awaddr,
    input  logic                         axi4_slave_awvalid,
    output logic                         axi4_slave_awready,
    input  logic [AXI_DATA_WIDTH-1:0]    axi4_slave_wdata,
    input  logic                         axi4_slave_wvalid,
    output logic                         axi4_slave_wready,
    output logic [1:0]                   axi4_slave_bresp,
    output logic                         axi4_slave_bvalid,
    input  logic                         axi4_slave_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]    axi4_slave_araddr,
    input  logic                         axi4_slave_arvalid,
    output logic                         axi4_slave_arready,
    output logic [AXI_DATA_WIDTH-1:0]    axi4_slave_rdata,
    output logic [1:0]                   axi4_slave_rresp,
    output logic                         axi4_slave_rvalid,
    input  logic                         axi4_slave_rready,
    input  logic                         jtag_tck,
    input  logic                         jtag_tdi,
    input  logic                         jtag_tms,
    input  logic                         jtag_trst_n,
    output logic                         jtag_tdo,
    input  logic                         mu2cgra_valid,
    output logic                         cgra2mu_ready,
    input  logic [31:0][16:0]            mu2cgra
);

    localparam int                  c_WIDX = $clog2(GLB_WORDS);
    localparam int                  c_STRB = PROC_DATA_WIDTH / 8;
    localparam logic [31:0]         c_ID   = 32'h4741_524E;

    logic [PROC_DATA_WIDTH-1:0] r_mem_q [GLB_WORDS];

    logic                       r_rd_v1_q,    w_rd_v1_d;
    logic [PROC_DATA_WIDTH-1:0] r_rd_data1_q, w_rd_data1_d;
    logic                       r_rd_valid_q, w_rd_valid_d;
    logic [PROC_DATA_WIDTH-1:0] r_rd_data_q,  w_rd_data_d;
    logic                       r_stall_q,    w_stall_d;
    logic [1:0]                 r_ier_q,      w_ier_d;
    logic [1:0]                 r_isr_q,      w_isr_d;
    logic [31:0]                r_cycle_cnt_q, w_cycle_cnt_d;
    logic [31:0]                r_run_len_q,  w_run_len_d;
    logic [21:0]                r_mu_sum_q,   w_mu_sum_d;
    logic                       r_mu_ready_q, w_mu_ready_d;
    logic                       r_running_q,  w_running_d;
    logic                       r_irq_q,      w_irq_d;
    logic                       r_bvalid_q,   w_bvalid_d;
    logic                       r_rvalid_q,   w_rvalid_d;
    logic [31:0]                r_rdata_q,    w_rdata_d;
    logic                       r_cg_en_q;

    logic              w_wr_in_range, w_rd_in_range;
    logic [c_WIDX-1:0] w_wr_idx, w_rd_idx;
    logic              w_wr_fire, w_rd_fire, w_aw_hit, w_ar_hit;
    logic [2:0]        w_aw_sel, w_ar_sel;
    logic [31:0]       w_rd_mux, w_cnt_inc;
    logic              w_start, w_done_set, w_mu_fire;
    logic [1:0]        w_isr_clr;
    logic [21:0]       w_lane_sum;
    logic              w_unused_ok;

    assign w_wr_idx      = proc_packet_wr_addr[c_WIDX+2:3];
    assign w_rd_idx      = proc_packet_rd_addr[c_WIDX+2:3];
    assign w_wr_in_range = (proc_packet_wr_addr[PROC_ADDR_WIDTH-1:c_WIDX+3] == '0);
    assign w_rd_in_range = (proc_packet_rd_addr[PROC_ADDR_WIDTH-1:c_WIDX+3] == '0);

    assign w_wr_fire = axi4_slave_awvalid & axi4_slave_wvalid & ~r_bvalid_q & ~reset_in;
    assign w_rd_fire = axi4_slave_arvalid & ~r_rvalid_q & ~reset_in;
    assign w_aw_hit  = (axi4_slave_awaddr[AXI_ADDR_WIDTH-1:5] == '0);
    assign w_ar_hit  = (axi4_slave_araddr[AXI_ADDR_WIDTH-1:5] == '0);
    assign w_aw_sel  = axi4_slave_awaddr[4:2];
    assign w_ar_sel  = axi4_slave_araddr[4:2];
    assign w_cnt_inc = r_cycle_cnt_q + 32'd1;

    always_ff @(posedge clk_in) begin
        if (proc_packet_wr_en && w_wr_in_range) begin
            for (int b = 0; b < c_STRB; b++) begin
                if (proc_packet_wr_strb[b]) begin
                    r_mem_q[w_wr_idx][b*8 +: 8] <= proc_packet_wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < 32; i++) begin
            w_lane_sum = w_lane_sum + {5'd0, mu2cgra[i]};
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_ar_hit) begin
            case (w_ar_sel)
                3'd0:    w_rd_mux = c_ID;
                3'd1:    w_rd_mux = {30'd0, r_stall_q, 1'b0};
                3'd2:    w_rd_mux = {30'd0, r_ier_q};
                3'd3:    w_rd_mux = {30'd0, r_isr_q};
                3'd4:    w_rd_mux = r_cycle_cnt_q;
                3'd5:    w_rd_mux = r_run_len_q;
                3'd6:    w_rd_mux = {10'd0, r_mu_sum_q};
                default: w_rd_mux = {31'd0, r_mu_ready_q};
            endcase
        end
    end

    always_comb begin
        // Stage 1 samples the array before this edge's write lands: read-before-write.
        w_rd_v1_d    = proc_packet_rd_en;
        w_rd_data1_d = (proc_packet_rd_en && w_rd_in_range) ? r_mem_q[w_rd_idx] : '0;
        w_rd_valid_d = r_rd_v1_q;
        w_rd_data_d  = r_rd_v1_q ? r_rd_data1_q : '0;

        w_stall_d    = r_stall_q;
        w_ier_d      = r_ier_q;
        w_run_len_d  = r_run_len_q;
        w_mu_ready_d = r_mu_ready_q;
        w_start      = 1'b0;
        w_isr_clr    = 2'b00;
        if (w_wr_fire && w_aw_hit) begin
            case (w_aw_sel)
                3'd1: begin
                    w_start   = axi4_slave_wdata[0];
                    w_stall_d = axi4_slave_wdata[1];
                end
                3'd2:    w_ier_d      = axi4_slave_wdata[1:0];
                3'd3:    w_isr_clr    = axi4_slave_wdata[1:0];
                3'd5:    w_run_len_d  = axi4_slave_wdata;
                3'd7:    w_mu_ready_d = axi4_slave_wdata[0];
                default: ;
            endcase
        end

        w_running_d   = r_running_q;
        w_cycle_cnt_d = r_cycle_cnt_q;
        w_done_set    = 1'b0;
        if (w_start) begin
            w_running_d   = 1'b1;
            w_cycle_cnt_d = '0;
        end else if (r_running_q) begin
            if (r_run_len_q == '0) begin
                w_running_d = 1'b0;
                w_done_set  = 1'b1;
            end else if (!r_stall_q) begin
                w_cycle_cnt_d = w_cnt_inc;
                if (w_cnt_inc == r_run_len_q) begin
                    w_running_d = 1'b0;
                    w_done_set  = 1'b1;
                end
            end
        end

        w_mu_fire  = mu2cgra_valid & r_mu_ready_q;
        w_mu_sum_d = w_mu_fire ? w_lane_sum : r_mu_sum_q;
        // Hardware set is OR-ed in after the clear so it wins a same-cycle W1C.
        w_isr_d    = (r_isr_q & ~w_isr_clr) | {w_mu_fire, w_done_set};
        w_irq_d    = |(r_isr_q & r_ier_q);

        w_bvalid_d = r_bvalid_q ? ~axi4_slave_bready : w_wr_fire;
        w_rvalid_d = r_rvalid_q ? ~axi4_slave_rready : w_rd_fire;
        w_rdata_d  = w_rd_fire ? w_rd_mux : r_rdata_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_rd_v1_q     <= 1'b0;
            r_rd_data1_q  <= '0;
            r_rd_valid_q  <= 1'b0;
            r_rd_data_q   <= '0;
            r_stall_q     <= 1'b0;
            r_ier_q       <= '0;
            r_isr_q       <= '0;
            r_cycle_cnt_q <= '0;
            r_run_len_q   <= '0;
            r_mu_sum_q    <= '0;
            r_mu_ready_q  <= 1'b0;
            r_running_q   <= 1'b0;
            r_irq_q       <= 1'b0;
            r_bvalid_q    <= 1'b0;
            r_rvalid_q    <= 1'b0;
            r_rdata_q     <= '0;
        end else begin
            r_rd_v1_q     <= w_rd_v1_d;
            r_rd_data1_q  <= w_rd_data1_d;
            r_rd_valid_q  <= w_rd_valid_d;
            r_rd_data_q   <= w_rd_data_d;
            r_stall_q     <= w_stall_d;
            r_ier_q       <= w_ier_d;
            r_isr_q       <= w_isr_d;
            r_cycle_cnt_q <= w_cycle_cnt_d;
            r_run_len_q   <= w_run_len_d;
            r_mu_sum_q    <= w_mu_sum_d;
            r_mu_ready_q  <= w_mu_ready_d;
            r_running_q   <= w_running_d;
            r_irq_q       <= w_irq_d;
            r_bvalid_q    <= w_bvalid_d;
            r_rvalid_q    <= w_rvalid_d;
            r_rdata_q     <= w_rdata_d;
        end
    end

    // Enable only changes while clk_in is low, so the AND never chops a high phase.
    always_latch begin
        if (!clk_in) begin
            r_cg_en_q = r_running_q & ~r_stall_q;
        end
    end

    assign cgra_running_clk_out      = clk_in & r_cg_en_q;
    assign interrupt                 = r_irq_q;
    assign proc_packet_rd_data       = r_rd_data_q;
    assign proc_packet_rd_data_valid = r_rd_valid_q;
    assign axi4_slave_awready        = w_wr_fire;
    assign axi4_slave_wready         = w_wr_fire;
    assign axi4_slave_bresp          = 2'b00;
    assign axi4_slave_bvalid         = r_bvalid_q;
    assign axi4_slave_arready        = w_rd_fire;
    assign axi4_slave_rdata          = r_rdata_q;
    assign axi4_slave_rresp          = 2'b00;
    assign axi4_slave_rvalid         = r_rvalid_q;
    assign cgra2mu_ready             = r_mu_ready_q;
    assign jtag_tdo                  = 1'b0;

    assign w_unused_ok = &{1'b0, jtag_tck, jtag_tdi, jtag_tms, jtag_trst_n,
                           proc_packet_wr_addr[2:0], proc_packet_rd_addr[2:0],
                           axi4_slave_awaddr[1:0], axi4_slave_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_garnet_shell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_garnet_shell                                                 |
// | Purpose  : Directed self-checking bench for garnet_shell.                  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_garnet_shell;

    logic             clk_in = 1'b0;
    logic             reset_in;
    logic             interrupt, cgra_running_clk_out;
    logic             wr_en, rd_en, rd_valid;
    logic [7:0]       wr_strb;
    logic [18:0]      wr_addr, rd_addr;
    logic [63:0]      wr_data, rd_data;
    logic [12:0]      awaddr, araddr;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [31:0]      wdata, rdata;
    logic [1:0]       bresp, rresp;
    logic             jtag_tdo;
    logic             mu_valid, mu_ready;
    logic [31:0][16:0] mu_lanes;

    int n_checks = 0;
    int n_pass   = 0;

    garnet_shell dut (
        .clk_in                    (clk_in),
        .reset_in                  (reset_in),
        .interrupt                 (interrupt),
        .cgra_running_clk_out      (cgra_running_clk_out),
        .proc_packet_wr_en         (wr_en),
        .proc_packet_wr_strb       (wr_strb),
        .proc_packet_wr_addr       (wr_addr),
        .proc_packet_wr_data       (wr_data),
        .proc_packet_rd_en         (rd_en),
        .proc_packet_rd_addr       (rd_addr),
        .proc_packet_rd_data       (rd_data),
        .proc_packet_rd_data_valid (rd_valid),
        .axi4_slave_awaddr         (awaddr),
        .axi4_slave_awvalid        (awvalid),
        .axi4_slave_awready        (awready),
        .axi4_slave_wdata          (wdata),
        .axi4_slave_wvalid         (wvalid),
        .axi4_slave_wready         (wready),
        .axi4_slave_bresp          (bresp),
        .axi4_slave_bvalid         (bvalid),
        .axi4_slave_bready         (bready),
        .axi4_slave_araddr         (araddr),
        .axi4_slave_arvalid        (arvalid),
        .axi4_slave_arready        (arready),
        .axi4_slave_rdata          (rdata),
        .axi4_slave_rresp          (rresp),
        .axi4_slave_rvalid         (rvalid),
        .axi4_slave_rready         (rready),
        .jtag_tck                  (1'b0),
        .jtag_tdi                  (1'b0),
        .jtag_tms                  (1'b0),
        .jtag_trst_n               (1'b1),
        .jtag_tdo                  (jtag_tdo),
        .mu2cgra_valid             (mu_valid),
        .cgra2mu_ready             (mu_ready),
        .mu2cgra                   (mu_lanes)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic axi_write(input logic [12:0] a, input logic [31:0] d);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        while (!awready && n < 20) begin
            tick(1);
            n++;
        end
        check("awready", awready, 1'b1);
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid", bvalid, 1'b1);
        tick(1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [12:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        #1;
        while (!arready && n < 20) begin
            tick(1);
            n++;
        end
        check("arready", arready, 1'b1);
        tick(1);
        arvalid = 1'b0;
        check("rvalid", rvalid, 1'b1);
        check("rresp", rresp, 2'b00);
        d = rdata;
        tick(1);
        rready = 1'b0;
    endtask

    task automatic proc_write(input logic [18:0] a, input logic [63:0] d, input logic [7:0] s);
        wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic proc_read_check(input string tag, input logic [18:0] a, input logic [63:0] exp);
        rd_addr = a; rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check({tag, "_early"}, rd_valid, 1'b0);
        tick(1);
        check({tag, "_valid"}, rd_valid, 1'b1);
        check(tag, rd_data, exp);
        tick(1);
        check({tag, "_drop"}, rd_valid, 1'b0);
        check({tag, "_zero"}, rd_data, 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        reset_in = 1'b1;
        wr_en = 0; wr_strb = 0; wr_addr = 0; wr_data = 0;
        rd_en = 0; rd_addr = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0;
        mu_valid = 0; mu_lanes = '0;
        tick(3);
        reset_in = 1'b0;

        check("rst_irq", interrupt, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_mu_ready", mu_ready, 1'b0);
        check("rst_runclk", cgra_running_clk_out, 1'b0);
        check("rst_tdo", jtag_tdo, 1'b0);

        axi_read(13'h00, r); check("id", r, 32'h4741_524E);
        axi_read(13'h40, r); check("unmapped", r, 32'd0);
        axi_read(13'h10, r); check("rst_cycle_cnt", r, 32'd0);

        proc_write(19'h10, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
        proc_write(19'h10, 64'h1122_3344_5566_7788, 8'h0F);
        proc_read_check("glb_partial", 19'h10, 64'hAAAA_BBBB_5566_7788);
        proc_write(19'h00, 64'h0000_0000_DEAD_BEEF, 8'hFF);
        proc_write(19'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        proc_read_check("glb_oor_wr", 19'h00, 64'h0000_0000_DEAD_BEEF);
        proc_read_check("glb_oor_rd", 19'h2000, 64'd0);

        // Same-cycle read/write, then an out-of-range and a re-read, back to back.
        rd_en = 1'b1; rd_addr = 19'h10;
        wr_en = 1'b1; wr_addr = 19'h10; wr_data = 64'h0123_4567_89AB_CDEF; wr_strb = 8'hFF;
        tick(1);
        wr_en = 1'b0; rd_addr = 19'h7FFF8;
        check("pipe_v0", rd_valid, 1'b0);
        tick(1);
        rd_addr = 19'h10;
        check("pipe_v1", rd_valid, 1'b1);
        check("pipe_rbw", rd_data, 64'hAAAA_BBBB_5566_7788);
        tick(1);
        rd_en = 1'b0;
        check("pipe_v2", rd_valid, 1'b1);
        check("pipe_oor", rd_data, 64'd0);
        tick(1);
        check("pipe_v3", rd_valid, 1'b1);
        check("pipe_new", rd_data, 64'h0123_4567_89AB_CDEF);
        tick(1);
        check("pipe_v4", rd_valid, 1'b0);

        axi_write(13'h14, 32'd5);
        axi_write(13'h08, 32'd1);
        axi_write(13'h04, 32'd1);
        tick(10);
        axi_read(13'h10, r); check("run5_cnt", r, 32'd5);
        axi_read(13'h0C, r); check("run5_isr", r, 32'd1);
        check("run5_irq", interrupt, 1'b1);
        axi_write(13'h0C, 32'd1);
        check("irq_clear", interrupt, 1'b0);
        axi_read(13'h0C, r); check("isr_clear", r, 32'd0);

        axi_write(13'h14, 32'd100);
        axi_write(13'h04, 32'd1);
        check("runclk_on", cgra_running_clk_out, 1'b1);
        axi_write(13'h04, 32'd2);
        check("runclk_stall", cgra_running_clk_out, 1'b0);
        axi_read(13'h04, r); check("ctrl_rd", r, 32'd2);
        axi_read(13'h10, r); check("stall_cnt_a", r, 32'd2);
        tick(3);
        check("runclk_stall2", cgra_running_clk_out, 1'b0);
        axi_read(13'h10, r); check("stall_cnt_b", r, 32'd2);
        axi_write(13'h04, 32'd0);
        check("runclk_resume", cgra_running_clk_out, 1'b1);
        axi_read(13'h10, r); check("resume_cnt", r, 32'd3);

        axi_write(13'h14, 32'd0);
        tick(2);
        axi_write(13'h0C, 32'd3);
        axi_write(13'h04, 32'd1);
        tick(2);
        axi_read(13'h10, r); check("len0_cnt", r, 32'd0);
        axi_read(13'h0C, r); check("len0_isr", r, 32'd1);
        axi_write(13'h0C, 32'd1);

        axi_write(13'h1C, 32'd1);
        check("mu_ready_on", mu_ready, 1'b1);
        for (int i = 0; i < 32; i++) mu_lanes[i] = 17'h1FFFF;
        mu_valid = 1'b1;
        tick(1);
        mu_valid = 1'b0;
        axi_read(13'h18, r); check("mu_sum_max", r, 32'd4194272);
        axi_read(13'h0C, r); check("mu_isr", r, 32'd2);
        check("mu_no_irq", interrupt, 1'b0);
        axi_write(13'h0C, 32'd2);
        for (int i = 0; i < 32; i++) mu_lanes[i] = 17'(i);
        mu_valid = 1'b1;
        tick(1);
        mu_valid = 1'b0;
        axi_read(13'h18, r); check("mu_sum_ramp", r, 32'd496);
        axi_write(13'h0C, 32'd2);
        axi_write(13'h1C, 32'd0);
        check("mu_ready_off", mu_ready, 1'b0);
        for (int i = 0; i < 32; i++) mu_lanes[i] = 17'd1;
        mu_valid = 1'b1;
        tick(1);
        mu_valid = 1'b0;
        axi_read(13'h18, r); check("mu_nocap_sum", r, 32'd496);
        axi_read(13'h0C, r); check("mu_nocap_isr", r, 32'd0);

        awaddr = 13'h14; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        #1;
        check("aw_wait0", awready, 1'b0);
        tick(1);
        check("aw_wait1", awready, 1'b0);
        tick(1);
        wdata = 32'h77; wvalid = 1'b1;
        #1;
        check("aw_fire", awready, 1'b1);
        check("w_fire", wready, 1'b1);
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("b_hold", bvalid, 1'b1);
            check("bresp", bresp, 2'b00);
            tick(1);
        end
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        check("b_done", bvalid, 1'b0);
        axi_read(13'h14, r); check("split_wr", r, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
